// File: rtl/cpu_pkg.sv
// Shared definitions for the tiny-CPU datapath: opcode encodings and the
// instruction-store load/fetch state type.
package cpu_pkg;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_t;

endpackage

// File: rtl/ram_core_sp.sv
// Single-port style storage: one write port and one registered read port.
// The read register only updates when a read is requested, so it holds its value otherwise.
module ram_core_sp #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // The array is deliberately left out of reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/prog_ram_loadable.sv
// Loadable instruction store: streamed program load with an auto-incrementing
// write pointer, and a 1-cycle fetch port that returns HLT_CODE past the program end.
module prog_ram_loadable
  import cpu_pkg::*;
#(
  parameter int              DATA_W   = 2,
  parameter int              ADDR_W   = 2,
  parameter logic [DATA_W-1:0] HLT_CODE = OP_HLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_oob,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic              word_acc, fetch_acc, last_word;
  logic [DATA_W-1:0] ram_rdata;

  // load_start takes priority over both handshakes in the same cycle.
  assign load_ready  = (state == LOAD) && !load_start;
  assign fetch_ready = (state == READY) && !load_start;
  assign busy        = (state == LOAD);
  assign word_acc    = load_valid && load_ready;
  assign fetch_acc   = fetch_req && fetch_ready;
  assign last_word   = word_acc && (load_last || (wr_ptr == ADDR_W'(DEPTH - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY, READY: begin
        if (load_start) state_next = LOAD;
      end
      LOAD: begin
        if (load_start)     state_next = LOAD;
        else if (last_word) state_next = READY;
      end
      default: state_next = EMPTY;
    endcase
  end

  // prog_len stays 0 during a load and is only published on the closing word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      prog_len <= '0;
    end else if (load_start) begin
      wr_ptr   <= '0;
      prog_len <= '0;
    end else if (word_acc) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (last_word) begin
        prog_len <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_oob   <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_oob <= !({1'b0, fetch_addr} < prog_len);
      end
    end
  end

  ram_core_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (word_acc),
    .waddr(wr_ptr),
    .wdata(load_data),
    .re   (fetch_acc),
    .raddr(fetch_addr),
    .rdata(ram_rdata)
  );

  assign fetch_data = fetch_oob ? HLT_CODE : ram_rdata;

endmodule

// File: tb/tb_prog_ram_loadable.sv
// Self-checking bench for prog_ram_loadable: a program-level reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_prog_ram_loadable;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic       load_start;
  logic       load_valid;
  logic [1:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       fetch_req;
  logic [1:0] fetch_addr;
  logic       fetch_ready;
  logic       fetch_valid;
  logic [1:0] fetch_data;
  logic       fetch_oob;
  logic [2:0] prog_len;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;

  prog_ram_loadable #(
    .DATA_W  (2),
    .ADDR_W  (2),
    .HLT_CODE(OP_HLT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .fetch_oob  (fetch_oob),
    .prog_len   (prog_len),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a program being streamed in, the published program, and the last fetch result.
  bit         m_loading;
  bit         m_have_prog;
  int         m_len;
  int         m_cnt;
  logic [1:0] m_mem [4];
  logic       e_valid;
  logic [1:0] e_data;
  logic       e_oob;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_loading   = 0;
      m_have_prog = 0;
      m_len       = 0;
      m_cnt       = 0;
      e_valid     = 1'b0;
      e_data      = 2'b00;
      e_oob       = 1'b0;
    end else begin
      if (m_have_prog && !load_start && fetch_req) begin
        e_valid = 1'b1;
        if (int'(fetch_addr) < m_len) begin
          e_data = m_mem[fetch_addr];
          e_oob  = 1'b0;
        end else begin
          e_data = OP_HLT;
          e_oob  = 1'b1;
        end
      end else begin
        e_valid = 1'b0;
      end
      if (load_start) begin
        m_loading   = 1;
        m_have_prog = 0;
        m_cnt       = 0;
        m_len       = 0;
      end else if (m_loading && load_valid) begin
        m_mem[m_cnt] = load_data;
        m_cnt++;
        if (load_last || m_cnt == 4) begin
          m_loading   = 0;
          m_have_prog = 1;
          m_len       = m_cnt;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: inputs settle after the falling edge, so check 2ns later.
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      checkOutput("model_load_ready",  int'(load_ready),  int'(m_loading && !load_start));
      checkOutput("model_fetch_ready", int'(fetch_ready), int'(m_have_prog && !load_start));
      checkOutput("model_busy",        int'(busy),        int'(m_loading));
      checkOutput("model_prog_len",    int'(prog_len),    m_len);
      checkOutput("model_fetch_valid", int'(fetch_valid), int'(e_valid));
      checkOutput("model_fetch_data",  int'(fetch_data),  int'(e_data));
      checkOutput("model_fetch_oob",   int'(fetch_oob),   int'(e_oob));
    end
  end

  task automatic applyStimulus(input logic ls, input logic lv, input logic [1:0] ld,
                               input logic ll, input logic fr, input logic [1:0] fa);
    @(negedge clk);
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    fetch_req  = fr;
    fetch_addr = fa;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic loadWord(input logic [1:0] d, input logic last);
    applyStimulus(1'b0, 1'b1, d, last, 1'b0, 2'b00);
  endtask

  task automatic fetch(input logic [1:0] a);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, a);
  endtask

  task automatic startLoad();
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    fetch_req = 0; fetch_addr = 0;
    @(negedge clk);
    @(negedge clk);
    check_en = 1;
    @(negedge clk);
    rst = 1'b0;

    // Scenario 1: fetch right after reset is refused
    fetch(2'd0);
    #2;
    checkOutput("s1_fetch_ready", int'(fetch_ready), 0);
    checkOutput("s1_prog_len", int'(prog_len), 0);
    idle();
    #2;
    checkOutput("s1_fetch_valid", int'(fetch_valid), 0);
    checkOutput("s1_fetch_data", int'(fetch_data), 0);

    // Scenario 2: four-word program, back-to-back fetches
    startLoad();
    loadWord(OP_INC, 1'b0);
    #2;
    checkOutput("s2_busy", int'(busy), 1);
    loadWord(OP_JNO, 1'b0);
    loadWord(2'b00, 1'b0);
    loadWord(OP_HLT, 1'b1);
    fetch(2'd0);
    #2;
    checkOutput("s2_prog_len", int'(prog_len), 4);
    checkOutput("s2_busy_done", int'(busy), 0);
    fetch(2'd1);
    #2;
    checkOutput("s2_valid0", int'(fetch_valid), 1);
    checkOutput("s2_data0", int'(fetch_data), 0);
    fetch(2'd2);
    #2;
    checkOutput("s2_data1", int'(fetch_data), 1);
    fetch(2'd3);
    #2;
    checkOutput("s2_data2", int'(fetch_data), 0);
    idle();
    #2;
    checkOutput("s2_data3", int'(fetch_data), 2);
    checkOutput("s2_oob3", int'(fetch_oob), 0);
    idle();
    #2;
    checkOutput("s2_valid_drop", int'(fetch_valid), 0);

    // Scenario 3: short program, out-of-range fetch returns HLT
    startLoad();
    loadWord(OP_JNO, 1'b0);
    loadWord(2'b00, 1'b1);
    fetch(2'd3);
    fetch(2'd0);
    #2;
    checkOutput("s3_data_oob", int'(fetch_data), 2);
    checkOutput("s3_oob", int'(fetch_oob), 1);
    checkOutput("s3_prog_len", int'(prog_len), 2);
    idle();
    #2;
    checkOutput("s3_data_in", int'(fetch_data), 1);
    checkOutput("s3_oob_clear", int'(fetch_oob), 0);

    // Scenario 4: load_start beats a same-cycle fetch
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
    #2;
    checkOutput("s4_fetch_ready", int'(fetch_ready), 0);
    idle();
    #2;
    checkOutput("s4_busy", int'(busy), 1);
    checkOutput("s4_prog_len", int'(prog_len), 0);
    checkOutput("s4_fetch_valid", int'(fetch_valid), 0);

    // Scenario 5: reset in the middle of a load
    loadWord(2'b11, 1'b0);
    loadWord(2'b01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("s5_busy", int'(busy), 0);
    checkOutput("s5_load_ready", int'(load_ready), 0);
    checkOutput("s5_prog_len", int'(prog_len), 0);
    fetch(2'd0);
    #2;
    checkOutput("s5_fetch_ready", int'(fetch_ready), 0);

    // Scenario 6: sparse load_valid, garbage data on idle cycles
    startLoad();
    loadWord(2'b11, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
    loadWord(2'b00, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
    #2;
    checkOutput("s6_still_busy", int'(busy), 1);
    loadWord(2'b01, 1'b1);
    fetch(2'd0);
    #2;
    checkOutput("s6_prog_len", int'(prog_len), 3);
    fetch(2'd1);
    #2;
    checkOutput("s6_data0", int'(fetch_data), 3);
    fetch(2'd2);
    #2;
    checkOutput("s6_data1", int'(fetch_data), 0);
    fetch(2'd3);
    #2;
    checkOutput("s6_data2", int'(fetch_data), 1);
    idle();
    #2;
    checkOutput("s6_data3", int'(fetch_data), 2);
    checkOutput("s6_oob3", int'(fetch_oob), 1);

    // Full-depth load without load_last, then restart mid-load
    startLoad();
    loadWord(2'b01, 1'b0);
    loadWord(2'b10, 1'b0);
    loadWord(2'b11, 1'b0);
    loadWord(2'b00, 1'b0);
    idle();
    #2;
    checkOutput("full_busy", int'(busy), 0);
    checkOutput("full_prog_len", int'(prog_len), 4);
    startLoad();
    loadWord(2'b01, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 2'b00);
    loadWord(2'b11, 1'b1);
    fetch(2'd0);
    #2;
    checkOutput("restart_prog_len", int'(prog_len), 1);
    fetch(2'd1);
    #2;
    checkOutput("restart_data0", int'(fetch_data), 3);
    idle();
    #2;
    checkOutput("restart_oob1", int'(fetch_oob), 1);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
